// File: rtl/vga_mem_arbiter.sv
// Pixel-memory arbiter: display reads take strict priority, host writes queue in a FIFO.
// Optional stall statistics are enabled by defining VGA_ARB_STATS_EN.
module vga_mem_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                          clk_pll,
  input  logic                          rst,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_valid,
  output logic [DATA_W-1:0]             disp_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   stall_cnt,
  input  logic                          frame_start
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StDisp, StHost} state_e;
  state_e state_q, state_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     level_q;
  logic              push, pop, full, empty;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [RD_LAT-1:0] rd_pipe_q;
  logic [RD_LAT:0]   rd_shift;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

  assign full     = (level_q == LevelFull);
  assign empty    = (level_q == '0);
  assign wr_ready = !rst && !full;
  assign push     = wr_valid && wr_ready;

  always_comb begin
    state_d = StIdle;
    pop     = 1'b0;
    if (disp_req) begin
      state_d = StDisp;
    end else if (!empty) begin
      state_d = StHost;
      pop     = 1'b1;
    end
  end

  always_ff @(posedge clk_pll or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus is registered from the decision, so it shows this cycle's choice next cycle.
  always_ff @(posedge clk_pll or posedge rst) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_d)
        StDisp: begin
          mem_en_q   <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= disp_addr;
        end
        StHost: begin
          mem_en_q    <= 1'b1;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= fifo_addr_q[rd_ptr_q];
          mem_wdata_q <= fifo_data_q[rd_ptr_q];
        end
        default: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk_pll) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk_pll or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Read-valid pipeline matched to memory latency; top tap marks mem_rdata valid.
  assign rd_shift = {rd_pipe_q, mem_en_q && !mem_we_q};

  always_ff @(posedge clk_pll or posedge rst) begin
    if (rst) begin
      rd_pipe_q    <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd_pipe_q    <= rd_shift[RD_LAT-1:0];
      disp_valid_q <= rd_shift[RD_LAT];
      disp_data_q  <= rd_shift[RD_LAT] ? mem_rdata : '0;
    end
  end

`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_pll or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (frame_start) begin
      stall_q <= '0;
    end else if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign stall_cnt          = '0;
`endif

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a 1-cycle memory model returning ~addr.
module tb_vga_mem_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int RD_LAT     = 1;

  logic                 clk_pll = 1'b0;
  logic                 rst = 1'b1;
  logic                 disp_req = 1'b0;
  logic [ADDR_W-1:0]    disp_addr = '0;
  logic                 disp_valid;
  logic [DATA_W-1:0]    disp_data;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic [ADDR_W-1:0]    wr_addr = '0;
  logic [DATA_W-1:0]    wr_data = '0;
  logic                 mem_en, mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata = '0;
  logic [3:0]           fifo_level;
  logic [15:0]          stall_cnt;
  logic                 frame_start = 1'b0;

  vga_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk_pll(clk_pll), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .stall_cnt(stall_cnt), .frame_start(frame_start)
  );

  always #5 clk_pll = ~clk_pll;

  always @(posedge clk_pll) begin
    if (mem_en && !mem_we) mem_rdata <= ~mem_addr[15:0];
  end

  int                cyc = 0;
  logic [ADDR_W-1:0] wq_addr [$];
  logic [DATA_W-1:0] wq_data [$];
  int                wq_cyc [$];

  always @(posedge clk_pll) cyc <= cyc + 1;

  always @(negedge clk_pll) begin
    if (mem_en && mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      wq_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_pll);
    #1;
  endtask

  task automatic drive_wr(input int idx);
    wr_addr = ADDR_W'(32'h100 + idx);
    wr_data = DATA_W'(32'hA000 + idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  sent;
    int  bad;
    int  n0;
    logic acc;

    // Reset
    repeat (5) step();
    check("rst_mem_en", mem_en, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_level", fifo_level, 0);
    check("rst_stall", stall_cnt, 0);
    rst = 1'b0;
    #1;
    check("rel_wr_ready", wr_ready, 1);
    check("rel_level", fifo_level, 0);
    step();

    // Idle write: mem_we exactly two cycles after acceptance
    wr_valid = 1'b1; wr_addr = 19'h00010; wr_data = 16'hF800;
    check("wr_ready_k", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    check("wr_k1_en", mem_en, 0);
    step();
    check("wr_k2_en", mem_en, 1);
    check("wr_k2_we", mem_we, 1);
    check("wr_k2_addr", mem_addr, 32'h10);
    check("wr_k2_wdata", mem_wdata, 32'hF800);
    check("wr_k2_level", fifo_level, 0);
    step();
    check("wr_k3_en", mem_en, 0);

    // Display read: data appears at k+3
    disp_req = 1'b1; disp_addr = 19'h00005;
    step();
    disp_req = 1'b0;
    check("rd_k1_en", mem_en, 1);
    check("rd_k1_we", mem_we, 0);
    check("rd_k1_addr", mem_addr, 5);
    step();
    check("rd_k2_valid", disp_valid, 0);
    step();
    check("rd_k3_valid", disp_valid, 1);
    check("rd_k3_data", disp_data, 32'hFFFA);
    step();
    check("rd_k4_valid", disp_valid, 0);
    check("rd_k4_data", disp_data, 0);

    // Priority: display holds the bus, FIFO fills to 8
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    sent = 0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(c);
      wr_valid = (sent < 10); drive_wr(sent);
      acc = wr_valid && wr_ready;
      if (c > 0) bad += int'(mem_we);
      step();
      if (acc) sent++;
    end
    bad += int'(mem_we);
    check("prio_accepted", sent, 8);
    check("prio_wr_ready", wr_ready, 0);
    check("prio_level", fifo_level, 8);
    check("prio_no_we", bad, 0);
    for (int c = 0; c < 20; c++) begin
      disp_req = 1'b0;
      wr_valid = (sent < 10); drive_wr(sent);
      acc = wr_valid && wr_ready;
      step();
      if (acc) sent++;
    end
    wr_valid = 1'b0;
    check("drain_sent", sent, 10);
    check("drain_count", wq_addr.size(), 10);
    bad = 0;
    for (int i = 0; i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== ADDR_W'(32'h100 + i) || wq_data[i] !== DATA_W'(32'hA000 + i)) bad++;
    end
    check("drain_order", bad, 0);
    if (wq_cyc.size() == 10) check("drain_b2b", wq_cyc[9] - wq_cyc[0], 9);
    else check("drain_b2b", wq_cyc.size(), 10);
    check("drain_level", fifo_level, 0);

    // Reset mid-drain at level 5
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      disp_req = 1'b1;
      wr_valid = (sent < 8); drive_wr(sent);
      acc = wr_valid && wr_ready;
      step();
      if (acc) sent++;
    end
    wr_valid = 1'b0;
    check("mid_fill", fifo_level, 8);
    disp_req = 1'b0;
    repeat (3) step();
    check("mid_level5", fifo_level, 5);
    n0 = wq_addr.size();
    rst = 1'b1;
    #1;
    check("mid_rst_we", mem_we, 0);
    repeat (3) step();
    check("mid_rst_ready", wr_ready, 0);
    rst = 1'b0;
    repeat (10) step();
    check("mid_no_more_we", wq_addr.size(), n0);
    check("mid_level0", fifo_level, 0);
    check("mid_en", mem_en, 0);

    // Stall statistics
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      disp_req = 1'b1;
      wr_valid = (sent < 8); drive_wr(sent);
      acc = wr_valid && wr_ready;
      step();
      if (acc) sent++;
    end
    check("st_full", fifo_level, 8);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wr_valid = 1'b1;
    repeat (12) step();
    wr_valid = 1'b0;
`ifdef VGA_ARB_STATS_EN
    check("st_count12", stall_cnt, 12);
`else
    check("st_tied0", stall_cnt, 0);
`endif
    wr_valid = 1'b1; frame_start = 1'b1;
    step();
    wr_valid = 1'b0; frame_start = 1'b0;
    check("st_clear", stall_cnt, 0);
    disp_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
